// File: rtl/multi_channel_traffic_generator_pkg.sv
// multi_channel_traffic_generator_pkg: channel config type, mode codes and LFSR helpers
package multi_channel_traffic_generator_pkg;
    localparam int TG_FLOW_ID_WIDTH = 8;
    localparam int TG_PRIO_WIDTH = 16;
    localparam int TG_RATE_WIDTH = 8;
    localparam int TG_BURST_WIDTH = 6;
    localparam int TG_COUNT_WIDTH = 32;
    localparam logic TG_MODE_BERNOULLI = 1'b0;
    localparam logic TG_MODE_BURST = 1'b1;

    typedef struct packed {
        logic enable;
        logic mode;
        logic [TG_RATE_WIDTH-1:0] injrate;
        logic [TG_BURST_WIDTH-1:0] burst_len;
        logic [TG_COUNT_WIDTH-1:0] total_packets;
        logic [TG_RATE_WIDTH-1:0] injrate_seed;
        logic [TG_FLOW_ID_WIDTH-1:0] flow_id_seed;
        logic [TG_PRIO_WIDTH-1:0] priority_seed;
    } TGChanConfig;

    typedef enum logic {IDLE, BURST} tg_state_t;

    // Fibonacci LFSRs; the feedback includes the msb, so a nonzero state never reaches zero
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    function automatic logic [7:0] seed8(input logic [7:0] s);
        return s == 8'd0 ? 8'd1 : s;
    endfunction

    function automatic logic [15:0] seed16(input logic [15:0] s);
        return s == 16'd0 ? 16'd1 : s;
    endfunction
endpackage

// File: rtl/multi_channel_traffic_generator_tg_channel.sv
// tg_channel: one traffic source with rate/flow/prio LFSRs, Bernoulli/burst FSM,
// a one-entry pending slot and saturating sent/drop counters
module tg_channel
    import multi_channel_traffic_generator_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  TGChanConfig cfg,
    input  logic gen_phase,
    input  logic grant,
    input  logic sent_inc,
    output logic full,
    output logic [TG_FLOW_ID_WIDTH-1:0] flow_id,
    output logic [TG_PRIO_WIDTH-1:0] prio,
    output logic finished,
    output logic [TG_COUNT_WIDTH-1:0] num_sent,
    output logic [TG_COUNT_WIDTH-1:0] num_drops
);
    localparam int BW = TG_BURST_WIDTH;
    localparam logic [TG_COUNT_WIDTH-1:0] CNT_MAX = '1;

    tg_state_t state;
    logic [TG_RATE_WIDTH-1:0] rate_lfsr;
    logic [TG_FLOW_ID_WIDTH-1:0] flow_lfsr;
    logic [TG_PRIO_WIDTH-1:0] prio_lfsr;
    logic [TG_COUNT_WIDTH-1:0] issued;
    logic [BW-1:0] remaining;
    logic eligible, slot_free, hit, capture;

    assign eligible = cfg.enable && issued < cfg.total_packets;
    assign finished = !eligible;
    // a slot granted this cycle can take a new packet at the same edge
    assign slot_free = !full || grant;
    assign hit = gen_phase && eligible && rate_lfsr < cfg.injrate;
    assign capture = state == IDLE ? hit && slot_free : gen_phase && eligible && slot_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            full <= 1'b0;
            flow_id <= '0;
            prio <= '0;
            issued <= '0;
            remaining <= '0;
            num_sent <= '0;
            num_drops <= '0;
            rate_lfsr <= seed8(cfg.injrate_seed);
            flow_lfsr <= seed8(cfg.flow_id_seed);
            prio_lfsr <= seed16(cfg.priority_seed);
        end else begin
            if (state == IDLE && gen_phase)
                rate_lfsr <= lfsr8_next(rate_lfsr);
            if (capture) begin
                full <= 1'b1;
                flow_id <= flow_lfsr;
                prio <= prio_lfsr;
                issued <= issued + 1'b1;
                flow_lfsr <= lfsr8_next(flow_lfsr);
                prio_lfsr <= lfsr16_next(prio_lfsr);
            end else if (grant) begin
                full <= 1'b0;
            end
            if (state == IDLE && hit && !slot_free && num_drops != CNT_MAX)
                num_drops <= num_drops + 1'b1;
            if (sent_inc && num_sent != CNT_MAX)
                num_sent <= num_sent + 1'b1;
            if (state == IDLE) begin
                if (capture && cfg.mode == TG_MODE_BURST && cfg.burst_len > BW'(1)) begin
                    state <= BURST;
                    remaining <= cfg.burst_len - 1'b1;
                end
            end else if (gen_phase) begin
                if (!eligible) begin
                    state <= IDLE;
                end else if (slot_free) begin
                    remaining <= remaining - 1'b1;
                    if (remaining == BW'(1))
                        state <= IDLE;
                end
            end
        end
    end
endmodule

// File: rtl/multi_channel_traffic_generator.sv
// multi_channel_traffic_generator: NUM_CHANNELS LFSR traffic channels merged by a
// round-robin arbiter into one registered valid/ready packet output
module multi_channel_traffic_generator
    import multi_channel_traffic_generator_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int FLOW_ID_WIDTH = TG_FLOW_ID_WIDTH,
    parameter int PRIO_WIDTH = TG_PRIO_WIDTH,
    parameter int COUNT_WIDTH = TG_COUNT_WIDTH,
    localparam int CH_W = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1,
    localparam int CFG_W = $bits(TGChanConfig)
) (
    input  logic clk,
    input  logic reset,
    input  logic [NUM_CHANNELS*CFG_W-1:0] i__config,
    input  logic i__generate_phase,
    input  logic i__ready,
    output logic o__valid,
    output logic [FLOW_ID_WIDTH-1:0] o__flow_id,
    output logic [PRIO_WIDTH-1:0] o__priority,
    output logic [CH_W-1:0] o__channel_id,
    output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] o__num_pkts_sent,
    output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] o__num_drops,
    output logic o__done
);
    logic [NUM_CHANNELS-1:0] full, grant, finished, sent_inc;
    logic [FLOW_ID_WIDTH-1:0] slot_flow [NUM_CHANNELS];
    logic [PRIO_WIDTH-1:0] slot_prio [NUM_CHANNELS];
    logic [CH_W-1:0] ptr, sel;
    logic found, take, handshake;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        tg_channel u_ch (
            .clk(clk),
            .reset(reset),
            .cfg(TGChanConfig'(i__config[c*CFG_W +: CFG_W])),
            .gen_phase(i__generate_phase),
            .grant(grant[c]),
            .sent_inc(sent_inc[c]),
            .full(full[c]),
            .flow_id(slot_flow[c]),
            .prio(slot_prio[c]),
            .finished(finished[c]),
            .num_sent(o__num_pkts_sent[c*COUNT_WIDTH +: COUNT_WIDTH]),
            .num_drops(o__num_drops[c*COUNT_WIDTH +: COUNT_WIDTH])
        );
    end

    // scan downwards so the full slot closest to ptr wins
    always_comb begin
        found = 1'b0;
        sel = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (full[(int'(ptr) + i) % NUM_CHANNELS]) begin
                found = 1'b1;
                sel = CH_W'((int'(ptr) + i) % NUM_CHANNELS);
            end
        end
    end

    assign handshake = o__valid && i__ready;
    assign take = found && (!o__valid || i__ready);
    assign grant = take ? NUM_CHANNELS'(1) << sel : '0;
    assign sent_inc = handshake ? NUM_CHANNELS'(1) << o__channel_id : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o__valid <= 1'b0;
            o__flow_id <= '0;
            o__priority <= '0;
            o__channel_id <= '0;
            ptr <= '0;
            o__done <= 1'b0;
        end else begin
            if (take) begin
                o__valid <= 1'b1;
                o__flow_id <= slot_flow[sel];
                o__priority <= slot_prio[sel];
                o__channel_id <= sel;
                ptr <= sel == CH_W'(NUM_CHANNELS - 1) ? '0 : sel + 1'b1;
            end else if (handshake) begin
                o__valid <= 1'b0;
            end
            o__done <= &finished && !(|full) && !o__valid;
        end
    end
endmodule
